// File: rtl/slink_pkg.sv
// Shared slink definitions: launcher state encoding and default sizing.
package slink_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GAP = 2'd1,
    WAIT_ACK = 2'd2
  } slink_state_e;

  localparam int SLINK_CNT_WIDTH = 4;
  localparam int SLINK_MIN_GAP   = 4;

endpackage

// File: rtl/slink_demet_reset.sv
// Two-flop synchronizer with asynchronous active-high reset.
// Ports: clk, reset, d (asynchronous input), q (synchronized output).
module slink_demet_reset (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/slink_pulse_launcher.sv
// Source side of a toggle-based pulse crossing. Each accepted pulse_in event
// becomes one flip of toggle_out; flips are spaced by a minimum-gap counter
// (USE_ACK=0) or by waiting for the returned ack toggle (USE_ACK=1). Events
// that cannot launch immediately queue in a saturating counter.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   pulse_in        one event per high cycle
//   ack_toggle_in   returned toggle from destination (USE_ACK=1 only)
//   toggle_out      flips once per launched event
//   pending_count   events accepted but not yet launched
//   busy            not idle or events pending
//   overflow        one-cycle pulse when an event is dropped
module slink_pulse_launcher
  import slink_pkg::*;
#(
  parameter int CNT_WIDTH = SLINK_CNT_WIDTH,
  parameter int MIN_GAP   = SLINK_MIN_GAP,
  parameter int USE_ACK   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pulse_in,
  input  logic                 ack_toggle_in,
  output logic                 toggle_out,
  output logic [CNT_WIDTH-1:0] pending_count,
  output logic                 busy,
  output logic                 overflow
);

  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (MIN_GAP > 1) ? GW'(MIN_GAP - 2) : '0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  slink_state_e         state, state_nxt;
  logic [GW-1:0]        gap, gap_nxt;
  logic [CNT_WIDTH-1:0] count_nxt;
  logic                 ack_sync;
  logic                 launch;
  logic                 drop;

  generate
    if (USE_ACK != 0) begin : g_ack
      slink_demet_reset u_ack_demet (
        .clk   (clk),
        .reset (reset),
        .d     (ack_toggle_in),
        .q     (ack_sync)
      );
    end else begin : g_no_ack
      logic unused_ack;
      assign unused_ack = ack_toggle_in;
      assign ack_sync   = 1'b0;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap;
    count_nxt = pending_count;
    launch    = (state == IDLE) && ((pending_count != '0) || pulse_in);
    // Saturated counter can only drop while not idle; an idle launch frees a slot.
    drop      = pulse_in && !launch && (pending_count == CNT_MAX);

    unique case ({pulse_in, launch})
      2'b10:   count_nxt = drop ? pending_count : pending_count + CNT_ONE;
      2'b01:   count_nxt = pending_count - CNT_ONE;
      default: count_nxt = pending_count;  // none, or direct/balanced launch
    endcase

    case (state)
      IDLE: begin
        if (launch) begin
          if (USE_ACK != 0) begin
            state_nxt = WAIT_ACK;
          end else if (MIN_GAP > 1) begin
            // Launch cycle plus MIN_GAP-2 countdown plus the zero cycle = MIN_GAP.
            state_nxt = WAIT_GAP;
            gap_nxt   = GAP_LOAD;
          end
        end
      end
      WAIT_GAP: begin
        if (gap == '0) state_nxt = IDLE;
        else           gap_nxt   = gap - GW'(1);
      end
      WAIT_ACK: begin
        if (ack_sync == toggle_out) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      gap           <= '0;
      pending_count <= '0;
      toggle_out    <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state         <= state_nxt;
      gap           <= gap_nxt;
      pending_count <= count_nxt;
      overflow      <= drop;
      if (launch) toggle_out <= ~toggle_out;
    end
  end

  assign busy = (state != IDLE) || (pending_count != '0);

endmodule

// File: tb/tb_slink_pulse_launcher.sv
module tb_slink_pulse_launcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic pa, pb, pc, pd, ack_c;
  logic ta, tb_, tc, td;
  logic [3:0] ca;
  logic [1:0] cb;
  logic [3:0] cc;
  logic [2:0] cd;
  logic ba, bb, bc, bd;
  logic oa, ob, oc, od;

  // A: defaults (gap 4). B: small counter, long gap. C: ack mode. D: gap 1.
  slink_pulse_launcher #(.CNT_WIDTH(4), .MIN_GAP(4), .USE_ACK(0)) u_a (
    .clk(clk), .reset(reset), .pulse_in(pa), .ack_toggle_in(1'b0),
    .toggle_out(ta), .pending_count(ca), .busy(ba), .overflow(oa));
  slink_pulse_launcher #(.CNT_WIDTH(2), .MIN_GAP(16), .USE_ACK(0)) u_b (
    .clk(clk), .reset(reset), .pulse_in(pb), .ack_toggle_in(1'b0),
    .toggle_out(tb_), .pending_count(cb), .busy(bb), .overflow(ob));
  slink_pulse_launcher #(.CNT_WIDTH(4), .MIN_GAP(4), .USE_ACK(1)) u_c (
    .clk(clk), .reset(reset), .pulse_in(pc), .ack_toggle_in(ack_c),
    .toggle_out(tc), .pending_count(cc), .busy(bc), .overflow(oc));
  slink_pulse_launcher #(.CNT_WIDTH(3), .MIN_GAP(1), .USE_ACK(0)) u_d (
    .clk(clk), .reset(reset), .pulse_in(pd), .ack_toggle_in(1'b0),
    .toggle_out(td), .pending_count(cd), .busy(bd), .overflow(od));

  int vecs = 0;
  int bad  = 0;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a launch is allowed once MIN_GAP cycles have elapsed
  // since the previous launch; events queue in a clamped integer count.
  typedef struct {
    int pend;
    bit tog;
    int last;
    int c;
    bit ovf;
  } mdl_t;

  function automatic void mstep(inout mdl_t m, input bit p, input int gap, input int maxc);
    bit idle;
    bit l;
    idle  = (m.c - m.last) >= gap;
    l     = idle && (m.pend > 0 || p);
    m.ovf = p && !l && (m.pend == maxc);
    if (l) begin
      m.tog  = !m.tog;
      m.last = m.c;
    end
    if (p && !m.ovf) m.pend++;
    if (l) m.pend--;
    m.c++;
  endfunction

  function automatic bit mbusy(input mdl_t m, input int gap);
    return ((m.c - m.last) < gap) || (m.pend > 0);
  endfunction

  typedef struct {
    bit p;
    bit tog;
    int cnt;
    bit busy;
  } vec_t;

  vec_t tbl [24];

  initial begin
    int flips;
    bit prev;
    mdl_t ma, md;

    // Expected outputs are the values visible after the edge closing each row's cycle.
    tbl = '{
      '{1,1,0,1}, '{1,1,1,1}, '{1,1,2,1}, '{0,1,2,1},
      '{0,0,1,1}, '{0,0,1,1}, '{0,0,1,1}, '{0,0,1,1},
      '{0,1,0,1}, '{0,1,0,1}, '{0,1,0,1}, '{0,1,0,0},
      '{1,0,0,1}, '{1,0,1,1}, '{0,0,1,1}, '{0,0,1,1},
      '{1,1,1,1}, '{0,1,1,1}, '{0,1,1,1}, '{0,1,1,1},
      '{0,0,0,1}, '{0,0,0,1}, '{0,0,0,1}, '{0,0,0,0}};

    reset = 1'b1;
    pa = 0; pb = 0; pc = 0; pd = 0; ack_c = 0;
    #1;
    chk("reset_tog", ta, 0);
    chk("reset_cnt", ca, 0);
    chk("reset_busy", ba, 0);
    chk("reset_ovf", oa, 0);
    tick();
    reset = 1'b0;

    // Single event, burst, and simultaneous event+launch on A.
    for (int i = 0; i < 24; i++) begin
      pa = tbl[i].p;
      tick();
      chk($sformatf("tbl%0d_tog", i), ta, tbl[i].tog);
      chk($sformatf("tbl%0d_cnt", i), ca, tbl[i].cnt);
      chk($sformatf("tbl%0d_busy", i), ba, tbl[i].busy);
      chk($sformatf("tbl%0d_ovf", i), oa, 0);
    end
    pa = 0;

    // Saturation on B: six back-to-back pulses.
    flips = 0;
    prev  = tb_;
    for (int k = 0; k < 6; k++) begin
      pb = 1;
      tick();
      if (tb_ != prev) flips++;
      prev = tb_;
      chk($sformatf("sat%0d_cnt", k), cb, (k < 3) ? k : 3);
      chk($sformatf("sat%0d_ovf", k), ob, (k >= 4) ? 1 : 0);
    end
    pb = 0;
    tick();
    if (tb_ != prev) flips++;
    prev = tb_;
    chk("sat_ovf_clear", ob, 0);
    for (int k = 0; k < 60; k++) begin
      tick();
      if (tb_ != prev) flips++;
      prev = tb_;
    end
    chk("sat_flips", flips, 4);
    chk("sat_drained", cb, 0);

    // Ack mode on C.
    flips = 0;
    prev  = tc;
    for (int k = 0; k < 22; k++) begin
      pc = (k < 2);
      tick();
      if (tc != prev) flips++;
      prev = tc;
    end
    pc = 0;
    chk("ack_one_flip", flips, 1);
    chk("ack_busy", bc, 1);
    chk("ack_pending", cc, 1);
    ack_c = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("ack_T+%0d_tog", k), tc, 1);
    end
    tick();
    chk("ack_T+4_tog", tc, 0);
    chk("ack_T+4_cnt", cc, 0);
    ack_c = 0;
    repeat (6) tick();
    chk("ack_idle_busy", bc, 0);
    chk("ack_idle_tog", tc, 0);

    // Reset mid-burst on A.
    for (int k = 0; k < 4; k++) begin
      pa = 1;
      tick();
    end
    pa = 0;
    chk("pre_rst_tog", ta, 1);
    chk("pre_rst_cnt", ca, 3);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_tog", ta, 0);
    chk("rst_async_cnt", ca, 0);
    chk("rst_async_busy", ba, 0);
    chk("rst_async_ovf", oa, 0);
    tick();
    reset = 1'b0;
    flips = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ta != 0) flips++;
    end
    chk("rst_no_flips", flips, 0);
    chk("rst_cnt_after", ca, 0);

    // Randomized traffic on A (gap 4) and D (gap 1) against the model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ma = '{pend: 0, tog: 0, last: -1000, c: 0, ovf: 0};
    md = '{pend: 0, tog: 0, last: -1000, c: 0, ovf: 0};
    for (int i = 0; i < 600; i++) begin
      int rate;
      rate = ((i / 100) % 2 == 0) ? 70 : 15;
      pa = ($urandom_range(0, 99) < rate);
      pd = ($urandom_range(0, 99) < rate + 20);
      mstep(ma, pa, 4, 15);
      mstep(md, pd, 1, 7);
      tick();
      chk("rndA_tog", ta, ma.tog);
      chk("rndA_cnt", ca, ma.pend);
      chk("rndA_ovf", oa, ma.ovf);
      chk("rndA_busy", ba, mbusy(ma, 4));
      chk("rndD_tog", td, md.tog);
      chk("rndD_cnt", cd, md.pend);
      chk("rndD_ovf", od, md.ovf);
      chk("rndD_busy", bd, mbusy(md, 1));
    end
    pa = 0;
    pd = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
